// File: rtl/nibble_serializer.sv
`default_nettype none
// ============================================================================
// nibble_serializer : FIFO-buffered parallel-to-serial shifter, MSB first,
//                     with first/last framing flags for each word.
// Revision: 1.0
// ============================================================================
module nibble_serializer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_bit,
    output logic                     out_valid,
    output logic                     out_first,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_idx_w = $clog2(WIDTH);

    localparam logic [c_idx_w-1:0] c_idx_msb  = c_idx_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [c_idx_w-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]     shifter_q, shifter_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];

    logic                 w_push;
    logic                 w_pop;
    logic                 w_not_empty;

    // Full is judged on the registered count only; a same-edge pop does not
    // open a slot early.
    assign in_ready    = (count_q != c_cnt_full);
    assign w_push      = in_valid && in_ready;
    assign w_not_empty = (count_q != '0);
    assign count       = count_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shifter_d = shifter_q;
        w_pop     = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_not_empty) begin
                    w_pop     = 1'b1;
                    shifter_d = mem_q[rd_ptr_q];
                    idx_d     = c_idx_msb;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                out_valid = 1'b1;
                out_bit   = shifter_q[idx_q];
                out_first = (idx_q == c_idx_msb);
                out_last  = (idx_q == '0);
                if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                end else if (w_not_empty) begin
                    // Back-to-back reload on the LSB edge keeps the stream gapless.
                    w_pop     = 1'b1;
                    shifter_d = mem_q[rd_ptr_q];
                    idx_d     = c_idx_msb;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shifter_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shifter_q <= shifter_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serializer.sv
`default_nettype none
// ============================================================================
// tb_nibble_serializer : scoreboard bench with an occupancy/bit-budget model.
// Revision: 1.0
// ============================================================================
module tb_nibble_serializer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             in_ready;
    logic             out_bit;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic [CW-1:0]    count;

    nibble_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_first (out_first),
        .out_last  (out_last),
        .count     (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] m_q[$];
    int               m_rem    = 0;
    bit               m_pushed = 1'b0;
    int               m_sz;
    bit               m_push;
    bit               m_pop;
    logic [WIDTH-1:0] m_dummy;

    int          v_cnt     = 0;
    int          v_first   = -1;
    int          v_last    = -1;
    int          cyc       = 0;
    logic [63:0] bits_seen = '0;
    bit          seen_full = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: words waiting in the FIFO plus bits left in the current word.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_rem    = 0;
            m_pushed = 1'b0;
        end else begin
            m_sz   = m_q.size();
            m_push = in_valid && (m_sz != DEPTH);
            m_pop  = (m_rem <= 1) && (m_sz > 0);
            if (m_pop) begin
                m_dummy = m_q.pop_front();
                m_rem   = WIDTH;
            end else if (m_rem > 0) begin
                m_rem--;
            end
            if (m_push) begin
                m_q.push_back(in_data);
                for (int i = WIDTH - 1; i >= 0; i--)
                    exp_q.push_back('{in_data[i], (i == WIDTH - 1), (i == 0)});
            end
            m_pushed = m_push;
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            chk("reset_outs", {out_valid, out_bit, out_first, out_last}, 4'b0);
            chk("reset_ready", in_ready, 1'b1);
            chk("reset_count", count, 0);
        end else begin
            chk("count", count, m_q.size());
            chk("in_ready", in_ready, (m_q.size() != DEPTH));
            chk("out_valid", out_valid, (m_rem > 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    fail("scoreboard_empty");
                end else begin
                    e = exp_q.pop_front();
                    chk("out_bit", out_bit, e.b);
                    chk("out_first", out_first, e.f);
                    chk("out_last", out_last, e.l);
                end
                v_cnt++;
                if (v_first < 0) v_first = cyc;
                v_last    = cyc;
                bits_seen = {bits_seen[62:0], out_bit};
            end else begin
                chk("idle_zero", {out_bit, out_first, out_last}, 3'b0);
            end
            if (count == CW'(DEPTH) && !in_ready) seen_full = 1'b1;
            cyc++;
        end
    end

    task automatic clear_stats();
        v_cnt     = 0;
        v_first   = -1;
        v_last    = -1;
        bits_seen = '0;
        seen_full = 1'b0;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (m_pushed) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) fail("push_timeout");
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (m_q.size() == 0 && m_rem == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail("idle_timeout");
    endtask

    initial begin
        logic [WIDTH-1:0] base;
        bit ok;

        // Reset held for 3 cycles, then an asynchronous pulse between edges
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_clear", {out_valid, out_bit, out_first, out_last}, 4'b0);
        chk("async_ready", in_ready, 1'b1);
        chk("async_count", count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word
        clear_stats();
        push_word(4'b1011);
        wait_idle();
        chk("single_len", v_cnt, 4);
        chk("single_bits", bits_seen[3:0], 4'b1011);

        // Stream 0..15
        clear_stats();
        for (int d = 0; d < 16; d++) push_word(WIDTH'(d));
        wait_idle();
        chk("stream_len", v_cnt, 64);
        chk("stream_contig", v_last - v_first + 1, 64);
        chk("stream_bits_hi", bits_seen[63:32], 32'h0123_4567);
        chk("stream_bits_lo", bits_seen[31:0], 32'h89AB_CDEF);

        // Full / backpressure with 8 distinct words
        clear_stats();
        base = WIDTH'($urandom_range(0, 15));
        for (int j = 0; j < 8; j++) push_word(base + WIDTH'(j * 5));
        wait_idle();
        chk("full_seen", seen_full, 1'b1);
        chk("full_len", v_cnt, 32);

        // Push coinciding with the LSB-edge reload while count==2
        push_word(WIDTH'($urandom));
        push_word(WIDTH'($urandom));
        push_word(WIDTH'($urandom));
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (count == CW'(2) && out_last) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail("simul_setup_timeout");
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        chk("simul_pushed", m_pushed, 1'b1);
        chk("simul_count", count, 2);
        chk("simul_no_bubble", {out_valid, out_first}, 2'b11);
        wait_idle();

        // Reset during the second bit of 4'b1100
        push_word(4'b1100);
        @(negedge clk);
        chk("mid_first", {out_valid, out_first, out_bit}, 3'b111);
        @(posedge clk);
        #2;
        chk("mid_second", {out_valid, out_first, out_bit}, 3'b101);
        rst_n = 1'b0;
        #1;
        chk("mid_clear", {out_valid, out_bit, out_first, out_last}, 4'b0);
        chk("mid_count", count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        repeat (8) @(negedge clk);
        chk("post_reset_quiet", v_cnt, 0);
        push_word(4'b0110);
        wait_idle();
        chk("post_reset_word", bits_seen[3:0], 4'b0110);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = WIDTH'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_idle();
        chk("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        fail("global_timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/nibble_serializer.md
# nibble_serializer

Parallel-to-serial front end for the sequence detector. It accepts WIDTH-bit words through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It then shifts each word out MSB-first, one bit per clock, producing the continuous serial `in` stream that the Mealy sequence detector consumes. Framing flags mark the first and last bit of each word so downstream logic and benches can align detector output to word boundaries.

## Interface

- WIDTH, 4, bits per word (≥2).
- DEPTH, 4, FIFO entries (power of two, ≥2).
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer presents a word.
- in_data  input  WIDTH  word to serialize, bit WIDTH-1 sent first.
- in_ready  output  1  FIFO can accept a word; combinational `count != DEPTH`.
- out_bit  output  1  serial bit; feeds detector `in`.
- out_valid  output  1  out_bit carries word data this cycle.
- out_first  output  1  out_bit is MSB of a word.
- out_last  output  1  out_bit is LSB of a word.
- count  output  $clog2(DEPTH)+1  FIFO occupancy. Excludes the word held in the shifter.

## Operation

- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Push: occurs when in_valid && in_ready at a rising edge. in_data is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Pop: occurs at the edge where the shifter loads. The head word is copied into the shift register, and rd_ptr wraps modulo DEPTH.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when push and pop happen on the same edge.
  - Never exceeds DEPTH and never underflows.
- Full FIFO: in_ready=0 whenever count==DEPTH, even if a pop happens that same edge. No bypass of the full condition.
- State machine (2 states, plus bit index `idx` in 0..WIDTH-1):
  - IDLE: out_valid=0, out_bit=0, out_first=0, out_last=0. If count>0 at the edge: pop, load shifter, idx←WIDTH-1, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: out_bit = shifter[idx], out_valid=1, out_first=(idx==WIDTH-1), out_last=(idx==0).
    - If idx>0: idx←idx−1.
    - If idx==0 and count>0: pop, reload, idx←WIDTH-1, stay in SHIFT. There is no gap cycle.
    - If idx==0 and count==0: go to IDLE.
- Outputs are registered from state, shifter and idx, so they contain no combinational path from in_*.
- No downstream backpressure: one bit is emitted every cycle while in SHIFT.
- Ordering: words leave strictly in push order. No word is dropped or duplicated.

## Timing

- Reset values: state=IDLE, wr_ptr=rd_ptr=0, count=0, shifter=0, idx=0. Outputs: out_bit=0, out_valid=0, out_first=0, out_last=0, in_ready=1.
- Reset is asynchronous: outputs clear immediately on rst_n falling, without waiting for a clock edge.
- Reset mid-operation: any partially shifted word and all buffered words are discarded.
  - After release, out_valid stays 0 until a new push.
  - The first rising edge after release is a normal edge.
- Latency from idle, with the word pushed at edge k:
  - The shifter loads at edge k+1.
  - The MSB is driven during cycle k+1..k+2.
  - The LSB is driven during cycle k+WIDTH..k+WIDTH+1.
- Throughput: one word per WIDTH cycles sustained, with no bubble between words while the FIFO is non-empty at each LSB edge.
- A push and a shifter reload on the same edge are both honoured. If count was 0, the pushed word is not visible to that reload; it loads at the next LSB edge or on the IDLE edge.
- Pointer wrap: after DEPTH pushes, wr_ptr returns to 0. Occupancy comes from count, not from pointer comparison.

## Test plan

- Reset: hold rst_n=0 for 3 cycles, then pulse rst_n low asynchronously between edges. Required: all outputs are 0 immediately, in_ready=1, count=0.
- Single word: push 4'b1011 at edge 1. Required:
  - out_valid=1 for exactly 4 cycles starting after edge 2.
  - out_bit sequence is 1,0,1,1.
  - out_first is high on cycle 1 only; out_last is high on cycle 4 only.
  - Then out_valid=0 and the block returns to IDLE.
- Stream 0..15: push words 4'h0 through 4'hF whenever in_ready. Required:
  - 64 contiguous valid bits with no gap after the first bit.
  - The bits equal each count MSB-first.
  - out_first recurs every 4 cycles.
- Full/backpressure: hold in_valid=1 with 8 distinct words, each presented until accepted. Required:
  - count reaches 4 and in_ready drops to 0 while count==4.
  - in_ready rises after the next pop.
  - All 8 words are emitted in order with no loss or duplication.
- Simultaneous push/pop: keep count==2, then push on an LSB edge. Required: count stays 2 and the next word starts with no bubble.
- Reset mid-word: push 4'b1100 and assert rst_n=0 during its second bit. Required:
  - Outputs clear at once.
  - After release, out_valid stays 0 until a new push, and the remaining bits 0,0 are never emitted.
